// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle chunked two's-complement adder/subtractor
//
// Adds or subtracts num_1 and num_2 CHUNK bits per clock, LSB chunk first.
// A carry register links one chunk to the next.
// Legal parameters: WIDTH >= 2 and WIDTH % CHUNK == 0.
//
// Ports:
//   clock, resetn       clock; asynchronous active-low reset
//   start               request an operation (accepted in IDLE or DONE)
//   sub, cin            0 = add with carry-in cin; 1 = num_1 - num_2 (cin ignored)
//   num_1, num_2        operands, latched when start is accepted
//   busy                high while chunks are being processed
//   done                one-cycle pulse when sum/carryOut/overflow update
//   sum                 WIDTH-bit result, modulo 2^WIDTH
//   carryOut            carry out of the MSB (for subtract: 1 = no borrow)
//   overflow            signed two's-complement overflow
module chunk_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the chunk index at least one bit wide for the CHUNK == WIDTH case.
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;       // already inverted for subtract
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_next;
  logic             carry;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  int               base;
  logic             last;
  logic             accept;

  // One chunk of the addition: never wider than CHUNK+1 bits.
  always_comb begin
    base         = int'(k) * CHUNK;
    a_chunk      = a_reg[base +: CHUNK];
    b_chunk      = b_reg[base +: CHUNK];
    chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    partial_next = partial;
    partial_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  assign last   = (k == KW'(NCHUNK - 1));
  // start is only looked at outside RUN, so a request mid-operation is dropped.
  assign accept = start && (state != RUN);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_reg    <= '0;
      b_reg    <= '0;
      partial  <= '0;
      carry    <= 1'b0;
      k        <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_reg   <= num_1;
      // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
      b_reg   <= sub ? ~num_2 : num_2;
      carry   <= sub ? 1'b1 : cin;
      partial <= '0;
      k       <= '0;
    end else if (state == RUN) begin
      partial <= partial_next;
      carry   <= chunk_sum[CHUNK];
      if (last) begin
        k        <= '0;
        // Outputs only ever see a completed result.
        sum      <= partial_next;
        carryOut <= chunk_sum[CHUNK];
        overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (partial_next[WIDTH-1] != a_reg[WIDTH-1]);
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - self-checking bench for chunk_serial_adder
module tb_chunk_serial_adder;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  // Main instance: WIDTH=8, CHUNK=2
  logic       start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] num_1 = '0, num_2 = '0;
  logic       busy, done, carry_out, ovf;
  logic [7:0] sum;

  // Sweep instance: WIDTH=8, CHUNK=8
  logic       s8_start = 1'b0, s8_sub = 1'b0, s8_cin = 1'b0;
  logic [7:0] s8_n1 = '0, s8_n2 = '0;
  logic       s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_sum;

  // Sweep instance: WIDTH=12, CHUNK=3
  logic        s12_start = 1'b0, s12_sub = 1'b0, s12_cin = 1'b0;
  logic [11:0] s12_n1 = '0, s12_n2 = '0;
  logic        s12_busy, s12_done, s12_cout, s12_ovf;
  logic [11:0] s12_sum;

  chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clock(clock), .resetn(resetn), .start(start), .sub(sub), .cin(cin),
    .num_1(num_1), .num_2(num_2), .busy(busy), .done(done), .sum(sum),
    .carryOut(carry_out), .overflow(ovf)
  );

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clock(clock), .resetn(resetn), .start(s8_start), .sub(s8_sub), .cin(s8_cin),
    .num_1(s8_n1), .num_2(s8_n2), .busy(s8_busy), .done(s8_done), .sum(s8_sum),
    .carryOut(s8_cout), .overflow(s8_ovf)
  );

  chunk_serial_adder #(.WIDTH(12), .CHUNK(3)) dut12 (
    .clock(clock), .resetn(resetn), .start(s12_start), .sub(s12_sub), .cin(s12_cin),
    .num_1(s12_n1), .num_2(s12_n2), .busy(s12_busy), .done(s12_done), .sum(s12_sum),
    .carryOut(s12_cout), .overflow(s12_ovf)
  );

  typedef struct packed {
    logic [11:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always @(posedge clock) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference model: full-width arithmetic, independent of chunking.
  function automatic exp_t model(input int w, input logic [11:0] a, input logic [11:0] b,
                                 input logic s, input logic c);
    logic [12:0] mask, aa, bp, full;
    exp_t r;
    mask  = (13'd1 << w) - 13'd1;
    aa    = {1'b0, a} & mask;
    bp    = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
    full  = aa + bp + (s ? 13'd1 : {12'd0, c});
    r.sum = full[11:0] & mask[11:0];
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bp[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  // Drive one operation on the main instance; returns #1 after the sampling edge E0.
  task automatic start_op(input logic s, input logic c, input logic [7:0] a,
                          input logic [7:0] b, input bit push);
    @(negedge clock);
    start = 1'b1; sub = s; cin = c; num_1 = a; num_2 = b;
    if (push) exp_q.push_back(model(8, {4'd0, a}, {4'd0, b}, s, c));
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Bounded wait for done on the main instance; also notes whether sum moved early.
  task automatic wait_main_done(output int cycles, output bit seen, output bit held);
    logic [7:0] s0;
    s0 = sum; held = 1'b1; seen = 1'b0; cycles = 0;
    while (!seen && cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (done === 1'b1) seen = 1'b1;
      else if (sum !== s0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({busy, done, sum, carry_out, ovf} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_main: got busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
               busy, done, sum, carry_out, ovf);
    end
    n_checks++;
    if ({s8_busy, s8_done, s8_sum, s8_cout, s8_ovf, s12_busy, s12_done, s12_sum, s12_cout, s12_ovf} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_sweep: got s8 sum=%h s12 sum=%h busy=%b/%b, need all 0",
               s8_sum, s12_sum, s8_busy, s12_busy);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    start_op(1'b0, 1'b0, 8'h7F, 8'h01, 1'b1);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clock);
      if (i < 4) begin
        n_checks++;
        if ({busy, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL latency_busy_%0d: got busy=%b done=%b, need 1 0", i, busy, done);
        end
      end else begin
        n_checks++;
        if ({busy, done} !== 2'b01) begin
          n_fail++;
          $display("FAIL latency_done: got busy=%b done=%b, need 0 1", busy, done);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({sum, carry_out, ovf} !== {e.sum[7:0], e.cout, e.ovf} || e.sum[7:0] !== 8'h80) begin
          n_fail++;
          $display("FAIL add_7f_01: got sum=%h cout=%b ovf=%b, need sum=80 cout=0 ovf=1",
                   sum, carry_out, ovf);
        end
      end
    end
    @(negedge clock);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_pulse_width: got busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_add_sub();
    logic [17:0] tbl [4];
    exp_t e;
    int cycles;
    bit seen, held;
    // {sub, cin, num_1, num_2}
    tbl[0] = {1'b0, 1'b1, 8'hFF, 8'h01};
    tbl[1] = {1'b0, 1'b1, 8'h10, 8'h20};
    tbl[2] = {1'b1, 1'b0, 8'h05, 8'h07};
    tbl[3] = {1'b1, 1'b1, 8'h80, 8'h01};
    for (int i = 0; i < 4; i++) begin
      start_op(tbl[i][17], tbl[i][16], tbl[i][15:8], tbl[i][7:0], 1'b1);
      wait_main_done(cycles, seen, held);
      n_checks++;
      if (!seen || cycles != 5) begin
        n_fail++;
        $display("FAIL op%0d_latency: got seen=%b cycles=%0d, need 1 5", i, seen, cycles);
      end
      n_checks++;
      if (!held) begin
        n_fail++;
        $display("FAIL op%0d_partial_visible: sum changed while busy, need held", i);
      end
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL op%0d_scoreboard: queue empty, need 1 entry", i);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({sum, carry_out, ovf} !== {e.sum[7:0], e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL op%0d_result: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                   i, sum, carry_out, ovf, e.sum[7:0], e.cout, e.ovf);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cycles, dc0;
    bit seen, held;
    @(negedge clock);
    dc0 = done_cnt;
    start_op(1'b0, 1'b0, 8'h03, 8'h04, 1'b1);
    @(posedge clock);
    #1 start = 1'b1; num_1 = 8'hAA; num_2 = 8'h55;
    @(posedge clock);
    #1 start = 1'b0;
    wait_main_done(cycles, seen, held);
    n_checks++;
    if (!seen || cycles != 3) begin
      n_fail++;
      $display("FAIL b2b_first_done: got seen=%b cycles=%0d, need 1 3", seen, cycles);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (sum !== e.sum[7:0] || e.sum[7:0] !== 8'h07) begin
      n_fail++;
      $display("FAIL b2b_ignore_start: got sum=%h, need 07", sum);
    end
    start = 1'b1; sub = 1'b0; cin = 1'b0; num_1 = 8'h01; num_2 = 8'h01;
    exp_q.push_back(model(8, 12'h001, 12'h001, 1'b0, 1'b0));
    @(posedge clock);
    #1 start = 1'b0;
    wait_main_done(cycles, seen, held);
    n_checks++;
    if (!seen || cycles != 5) begin
      n_fail++;
      $display("FAIL b2b_second_done: got seen=%b cycles=%0d, need 1 5", seen, cycles);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (sum !== e.sum[7:0]) begin
      n_fail++;
      $display("FAIL b2b_result: got sum=%h, need %h", sum, e.sum[7:0]);
    end
    repeat (8) @(negedge clock);
    n_checks++;
    if (done_cnt - dc0 != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d done pulses, need 2", done_cnt - dc0);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int cycles, dc0;
    bit seen, held;
    start_op(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, carry_out, ovf} !== 12'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
               busy, done, sum, carry_out, ovf);
    end
    dc0 = done_cnt;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (8) @(negedge clock);
    n_checks++;
    if (done_cnt != dc0 || {busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses busy=%b, need 0 and idle",
               done_cnt - dc0, busy);
    end
    start_op(1'b0, 1'b1, 8'h22, 8'h33, 1'b1);
    wait_main_done(cycles, seen, held);
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || {sum, carry_out, ovf} !== {e.sum[7:0], e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL after_reset_op: got seen=%b sum=%h, need 1 %h", seen, sum, e.sum[7:0]);
    end
  endtask

  task automatic test_param_sweep();
    exp_t e;
    // WIDTH=8, CHUNK=8
    @(negedge clock);
    s8_start = 1'b1; s8_n1 = 8'hC8; s8_n2 = 8'h64;
    exp_q.push_back(model(8, 12'h0C8, 12'h064, 1'b0, 1'b0));
    @(posedge clock);
    #1 s8_start = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({s8_busy, s8_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL c8_busy: got busy=%b done=%b, need 1 0", s8_busy, s8_done);
    end
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++;
    if ({s8_done, s8_sum, s8_cout, s8_ovf} !== {1'b1, e.sum[7:0], e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL c8_result: got done=%b sum=%h cout=%b ovf=%b, need 1 %h %b %b",
               s8_done, s8_sum, s8_cout, s8_ovf, e.sum[7:0], e.cout, e.ovf);
    end
    // WIDTH=12, CHUNK=3
    @(negedge clock);
    s12_start = 1'b1; s12_sub = 1'b1; s12_n1 = 12'h800; s12_n2 = 12'h001;
    exp_q.push_back(model(12, 12'h800, 12'h001, 1'b1, 1'b0));
    @(posedge clock);
    #1 s12_start = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clock);
      if (i < 4) begin
        n_checks++;
        if ({s12_busy, s12_done} !== 2'b10) begin
          n_fail++;
          $display("FAIL w12_busy_%0d: got busy=%b done=%b, need 1 0", i, s12_busy, s12_done);
        end
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({s12_done, s12_sum, s12_cout, s12_ovf} !== {1'b1, e.sum, e.cout, e.ovf} ||
            e.sum !== 12'h7FF) begin
          n_fail++;
          $display("FAIL w12_result: got done=%b sum=%h cout=%b ovf=%b, need 1 7ff %b %b",
                   s12_done, s12_sum, s12_cout, s12_ovf, e.cout, e.ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_add_sub();
    test_back_to_back();
    test_reset_mid_op();
    test_param_sweep();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, need 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

- Multi-cycle, parametrised two's-complement adder/subtractor.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with the carry passed between cycles in a register.
- Reports carry-out and signed overflow, using a start/busy/done handshake.
- Replaces fixed-width single-cycle ripple adders in the ALU datapath where wide operands would otherwise break timing.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; must be at least 2.
- CHUNK, default 2: bits added per cycle. WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
- clock, input, 1: single clock; all state changes on the rising edge.
- resetn, input, 1: asynchronous, active-low reset.
- start, input, 1: request an operation; sampled only when not busy.
- sub, input, 1: 0 = add, 1 = subtract (num_1 − num_2); latched with start.
- cin, input, 1: carry-in for add; ignored when sub=1.
- num_1, input, WIDTH: operand A; latched with start.
- num_2, input, WIDTH: operand B; latched with start.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse; results valid.
- sum, output, WIDTH: result.
- carryOut, output, 1: carry out of the MSB. For sub, 1 means no borrow.
- overflow, output, 1: signed two's-complement overflow.

## Operation
State machine with states IDLE, RUN and DONE.

IDLE:
- On start=1, latch A = num_1.
- Latch B' = sub ? ~num_2 : num_2.
- Set the carry register to sub ? 1 : cin.
- Clear the chunk index k to 0 and the partial-sum register; go to RUN.

RUN:
- Each cycle compute {c, s} = A[k] + B'[k] + carry over CHUNK bits.
- Write s into partial[k], store c in the carry register, increment k.
- When k = NCHUNK−1 is processed, go to DONE and load the outputs:
  - sum = full partial result;
  - carryOut = final carry;
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).

DONE:
- Lasts exactly one cycle, then returns to IDLE.
- start=1 in DONE is accepted: it latches new operands and goes to RUN (back-to-back operation).

Handshake rules:
- start while in RUN is ignored; there is no queueing.
- sum, carryOut and overflow hold their values until the next completion or reset. They never show partial results.

Reset:
- resetn=0 at any time, including mid-operation, forces IDLE.
- All outputs (busy, done, sum, carryOut, overflow) go to 0, as do all internal registers.
- An in-flight operation is discarded and no done is produced.

## Timing
- busy = 1 in RUN only; done = 1 in DONE only; the two are never high together.
- Latency, with start sampled at edge E0:
  - busy is high from E0 through E(NCHUNK);
  - chunk k is computed between E(k) and E(k+1);
  - outputs update at E(NCHUNK);
  - done is high for the cycle following E(NCHUNK).
- Throughput is one operation per NCHUNK+1 cycles with start held high.
- Degenerate case CHUNK = WIDTH: one RUN cycle; done is high after E1.
- Arithmetic is modulo 2^WIDTH; no internal value is wider than CHUNK+1 bits.

## Test plan
All scenarios use WIDTH=8, CHUNK=2 unless stated.

1. Add 0x7F + 0x01, cin=0 → after E4: sum=0x80, carryOut=0, overflow=1. busy high E0–E4, done high only in the cycle after E4.
2. Add 0xFF + 0x01, cin=1 → sum=0x01, carryOut=1, overflow=0. Also 0x10 + 0x20, cin=1 → sum=0x31, carryOut=0, overflow=0.
3. Subtract (sub=1):
   - 0x05 − 0x07 → sum=0xFE, carryOut=0, overflow=0;
   - 0x80 − 0x01 → sum=0x7F, carryOut=1, overflow=1.
4. Start ignored while busy:
   - start 0x03 + 0x04;
   - pulse start with 0xAA + 0x55 at E2;
   - required: result 0x07 and exactly one done pulse.
   - Then hold start in DONE with 0x01 + 0x01: next result 0x02, with done 5 cycles after the first done.
5. Reset mid-operation: assert resetn=0 during E2 → all outputs 0 immediately (asynchronous), state IDLE, no done pulse. A new operation after release completes normally.
6. Parameter sweep:
   - WIDTH=8, CHUNK=8: 0xC8 + 0x64 → sum=0x2C, carryOut=1, with done after E1.
   - WIDTH=12, CHUNK=3: 0x800 − 0x001 → sum=0x7FF, overflow=1.
